// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter
//   Shares the tile register bus between N_REQ masters, one transaction at a
//   time. Round-robin grant, a single outstanding transaction, and a one-cycle
//   response pulse to the granted requester. The target id is addr[15:8].
//
// Parameters
//   N_REQ    number of requesters (2..8)
//   N_TGT    number of register-bus targets
//   TIMEOUT  read-response timeout in cycles (only with REG_BUS_ARB_TIMEOUT_EN)
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_valid/write/addr/wdata   per-requester request (held until req_ready)
//   req_ready         one-hot accept pulse (combinational, IDLE only)
//   resp_valid        one-hot completion pulse; resp_data/resp_err valid with it
//   reg_bus_waddr/wdata/wvalid   write side of the register bus
//   reg_bus_araddr/arvalid       read request side of the register bus
//   reg_bus_rvalid/rdata         per-target read return
//
// Build option
//   REG_BUS_ARB_TIMEOUT_EN  adds a read timeout: err=1, data=32'hDEAD_BEEF.
//   Without it, WAIT_R holds until the addressed target answers.
module reg_bus_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned N_TGT   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [N_REQ-1:0]     req_write,
  input  logic [N_REQ*16-1:0]  req_addr,
  input  logic [N_REQ*32-1:0]  req_wdata,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic [15:0]          reg_bus_waddr,
  output logic [31:0]          reg_bus_wdata,
  output logic [N_TGT-1:0]     reg_bus_wvalid,
  output logic [N_TGT-1:0]     reg_bus_arvalid,
  output logic [15:0]          reg_bus_araddr,
  input  logic [N_TGT-1:0]     reg_bus_rvalid,
  input  logic [N_TGT*32-1:0]  reg_bus_rdata
);

  localparam int unsigned PW = $clog2(N_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_R, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  rr_ptr_q;
  logic [PW-1:0]  grant_q;
  logic [PW-1:0]  win;
  logic           found;
  logic           wr_q;
  logic [15:0]    addr_q;
  logic [31:0]    wdata_q;
  logic [31:0]    data_q;
  logic           err_q;
  logic [7:0]     tgt;
  logic           tgt_ok;
  logic [N_TGT-1:0] tgt_onehot;
  logic           sel_rvalid;
  logic [31:0]    sel_rdata;
  logic           expired;

  assign tgt        = addr_q[15:8];
  assign tgt_ok     = (32'(tgt) < N_TGT);
  assign tgt_onehot = tgt_ok ? ({{(N_TGT-1){1'b0}}, 1'b1} << tgt) : '0;

  assign reg_bus_waddr  = {8'h00, addr_q[7:0]};
  assign reg_bus_araddr = {8'h00, addr_q[7:0]};
  assign reg_bus_wdata  = wdata_q;
  assign resp_data      = data_q;
  assign resp_err       = err_q;

  // Round-robin pick: first valid requester at or after rr_ptr_q, cyclically.
  always_comb begin
    int unsigned idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[PW'(idx)]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Only the addressed target's return is observed; others are ignored.
  always_comb begin
    sel_rvalid = 1'b0;
    sel_rdata  = '0;
    for (int unsigned t = 0; t < N_TGT; t++) begin
      if (32'(tgt) == t) begin
        sel_rvalid = reg_bus_rvalid[t];
        sel_rdata  = reg_bus_rdata[t*32 +: 32];
      end
    end
  end

`ifdef REG_BUS_ARB_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  assign expired = (to_cnt_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst)                     to_cnt_q <= '0;
    else if (state_q == S_ISSUE) to_cnt_q <= '0;
    else if (state_q == S_WAIT_R) to_cnt_q <= to_cnt_q + 32'd1;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    req_ready       = '0;
    resp_valid      = '0;
    reg_bus_wvalid  = '0;
    reg_bus_arvalid = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready = {{(N_REQ-1){1'b0}}, 1'b1} << win;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!tgt_ok) begin
          state_d = S_RESP;
        end else if (wr_q) begin
          reg_bus_wvalid = tgt_onehot;
          state_d        = S_RESP;
        end else begin
          reg_bus_arvalid = tgt_onehot;
          state_d         = S_WAIT_R;
        end
      end
      S_WAIT_R: begin
        if (sel_rvalid || expired) state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = {{(N_REQ-1){1'b0}}, 1'b1} << grant_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Outputs are forced quiet while reset is held, whatever the state.
    if (rst) begin
      req_ready       = '0;
      resp_valid      = '0;
      reg_bus_wvalid  = '0;
      reg_bus_arvalid = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            grant_q  <= win;
            wr_q     <= req_write[win];
            addr_q   <= req_addr[win*16 +: 16];
            wdata_q  <= req_wdata[win*32 +: 32];
            rr_ptr_q <= (win == PW'(N_REQ - 1)) ? '0 : win + 1'b1;
          end
        end
        S_ISSUE: begin
          data_q <= '0;
          err_q  <= !tgt_ok;
        end
        S_WAIT_R: begin
          // A return in the expiry cycle takes priority over the timeout.
          if (sel_rvalid) begin
            data_q <= sel_rdata;
            err_q  <= 1'b0;
          end else if (expired) begin
            data_q <= 32'hDEAD_BEEF;
            err_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
`timescale 1ns/1ps
module tb_reg_bus_arbiter;

  localparam int NR = 4;
  localparam int NT = 32;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*16-1:0] req_addr;
  logic [NR*32-1:0] req_wdata;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   resp_valid;
  logic [31:0]     resp_data;
  logic            resp_err;
  logic [15:0]     reg_bus_waddr;
  logic [31:0]     reg_bus_wdata;
  logic [NT-1:0]   reg_bus_wvalid;
  logic [NT-1:0]   reg_bus_arvalid;
  logic [15:0]     reg_bus_araddr;
  logic [NT-1:0]   reg_bus_rvalid;
  logic [NT*32-1:0] reg_bus_rdata;

  reg_bus_arbiter #(.N_REQ(NR), .N_TGT(NT), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .reg_bus_waddr(reg_bus_waddr), .reg_bus_wdata(reg_bus_wdata),
    .reg_bus_wvalid(reg_bus_wvalid), .reg_bus_arvalid(reg_bus_arvalid),
    .reg_bus_araddr(reg_bus_araddr), .reg_bus_rvalid(reg_bus_rvalid), .reg_bus_rdata(reg_bus_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Target register contents: a fixed function of the full address.
  logic [15:0] seed16;
  function automatic logic [31:0] rd_val(input logic [15:0] a);
    if (a == 16'h0204) return 32'h0000_CAFE;
    return {a, a ^ seed16};
  endfunction

  // Scoreboard entries. exp_cyc < 0 means "one cycle after the target answered".
  typedef struct { int req; logic [31:0] data; logic err; int exp_cyc; bit hang; } resp_t;
  typedef struct { int cyc; logic [31:0] wv; logic [31:0] av; logic [15:0] addr; logic [31:0] wdata; } strb_t;

  resp_t rq[$];
  strb_t sq[$];
  int    grant_log[$];
  bit    m_busy = 0;
  int    m_ptr = 0;
  int    acc_cyc = 0;
  int    last_rv_cyc = -10;
  int    n_resp_seen = 0;
  int    silent_tgt = -1;
  int    force_lat = 0;
  bit    noise_en = 0;

  // Reference model and monitor: grant rule, strobe and response predictions.
  always @(negedge clk) begin
    logic [NR-1:0] exp_rdy;
    int win;
    resp_t r;
    strb_t s;
    logic [15:0] a;
    int t;
    if (rst) begin
      chk("ready_in_reset", 64'(req_ready), 64'h0);
      chk("resp_in_reset", 64'(resp_valid), 64'h0);
      m_busy = 0; m_ptr = 0;
      rq.delete(); sq.delete();
    end else begin
      exp_rdy = '0;
      win = -1;
      if (!m_busy)
        for (int k = 0; k < NR; k++)
          if (win < 0 && req_valid[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
      if (win >= 0) exp_rdy[win] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));

      if (win >= 0) begin
        a = req_addr[win*16 +: 16];
        t = int'(a[15:8]);
        s.cyc = cyc + 1; s.addr = {8'h00, a[7:0]}; s.wdata = req_wdata[win*32 +: 32];
        s.wv = '0; s.av = '0;
        r.req = win; r.hang = 0; r.data = '0; r.err = 1'b0; r.exp_cyc = cyc + 2;
        if (t >= NT) r.err = 1'b1;
        else if (req_write[win]) s.wv[t] = 1'b1;
        else begin
          s.av[t] = 1'b1;
          if (t == silent_tgt) begin
`ifdef REG_BUS_ARB_TIMEOUT_EN
            r.data = 32'hDEAD_BEEF; r.err = 1'b1; r.exp_cyc = cyc + 2 + TO;
`else
            r.hang = 1;
`endif
          end else begin
            r.data = rd_val(a); r.exp_cyc = -1;
          end
        end
        sq.push_back(s); rq.push_back(r); grant_log.push_back(win);
        m_busy = 1; m_ptr = (win + 1) % NR; acc_cyc = cyc;
      end

      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        s = sq.pop_front();
        chk("wvalid", 64'(reg_bus_wvalid), 64'(s.wv));
        chk("arvalid", 64'(reg_bus_arvalid), 64'(s.av));
        chk("waddr", 64'(reg_bus_waddr), 64'(s.addr));
        chk("araddr", 64'(reg_bus_araddr), 64'(s.addr));
        chk("wdata", 64'(reg_bus_wdata), 64'(s.wdata));
      end else if (reg_bus_wvalid != '0 || reg_bus_arvalid != '0) begin
        chk("stray_strobe", {reg_bus_wvalid, reg_bus_arvalid}, 64'h0);
      end

      if (resp_valid != '0) begin
        n_resp_seen++;
        if (rq.size() == 0 || rq[0].hang) chk("unexpected_resp", 64'(resp_valid), 64'h0);
        else begin
          r = rq.pop_front();
          chk("resp_valid", 64'(resp_valid), 64'(1) << r.req);
          chk("resp_data", 64'(resp_data), 64'(r.data));
          chk("resp_err", 64'(resp_err), 64'(r.err));
          chk("resp_cycle", 64'(cyc), 64'((r.exp_cyc >= 0) ? r.exp_cyc : last_rv_cyc + 1));
          m_busy = 0;
        end
      end else if (m_busy && rq.size() > 0 && !rq[0].hang && cyc > acc_cyc + 40) begin
        n_chk++; n_fail++;
        $display("FAIL resp_watchdog: no response %0d cycles after accept, required within 40", cyc - acc_cyc);
        rq.delete(); sq.delete(); m_busy = 0;
      end
    end
  end

  // Register-bus targets: answer reads after a latency, plus stray returns
  // from other targets that the arbiter must ignore.
  initial begin
    bit pend;
    int pt, cnt, nt;
    logic [15:0] pa;
    pend = 0; pt = 0; cnt = 0; pa = '0;
    reg_bus_rvalid = '0;
    reg_bus_rdata = '0;
    forever begin
      @(posedge clk); #1;
      reg_bus_rvalid = '0;
      for (int t = 0; t < NT; t++) reg_bus_rdata[t*32 +: 32] = $urandom;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          reg_bus_rvalid[pt] = 1'b1;
          reg_bus_rdata[pt*32 +: 32] = rd_val(pa);
          last_rv_cyc = cyc;
          pend = 0;
        end
      end
      if (noise_en && $urandom_range(0, 2) == 0) begin
        nt = int'($urandom_range(0, NT - 1));
        if (!(pend && nt == pt)) reg_bus_rvalid[nt] = 1'b1;
      end
      if (reg_bus_arvalid != '0) begin
        for (int t = 0; t < NT; t++)
          if (reg_bus_arvalid[t]) begin pt = t; pa = {8'(t), reg_bus_araddr[7:0]}; end
        if (pt != silent_tgt) begin
          pend = 1;
          cnt = (force_lat != 0) ? force_lat : int'($urandom_range(1, 6));
        end
      end
    end
  end

  // Requester state: each requester holds its request until accepted.
  bit          pv[NR];
  logic        pw[NR];
  logic [15:0] pa_q[NR];
  logic [31:0] pd[NR];

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = pv[i];
      req_write[i] = pw[i];
      req_addr[i*16 +: 16] = pa_q[i];
      req_wdata[i*32 +: 32] = pd[i];
    end
  endtask

  task automatic new_req(input int i, input logic wr);
    logic [7:0] tg;
    tg = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(NT, 255)) : 8'($urandom_range(0, NT - 1));
    pw[i] = wr; pa_q[i] = {tg, 8'($urandom)}; pd[i] = $urandom; pv[i] = 1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [15:0] a, input logic [31:0] d);
    pw[i] = wr; pa_q[i] = a; pd[i] = d; pv[i] = 1;
    drive();
  endtask

  // One cycle: observe accepts at negedge, update requesters, drive after posedge.
  task automatic step(input bit refill, input bit rnd);
    logic [NR-1:0] acc;
    @(negedge clk);
    acc = req_ready;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        if (refill) set_req(i, 1'b1, {8'($urandom_range(0, NT - 1)), 8'($urandom)}, $urandom);
        else pv[i] = 0;
      end else if (rnd) begin
        if (!pv[i] && $urandom_range(0, 3) == 0) new_req(i, 1'($urandom));
        else if (pv[i] && $urandom_range(0, 15) == 0) pv[i] = 0;
      end
    end
    @(posedge clk); #1;
    drive();
  endtask

  function automatic bit any_pend(input logic [NR-1:0] mask);
    for (int i = 0; i < NR; i++) if (mask[i] && pv[i]) return 1;
    return 0;
  endfunction

  task automatic wait_acc(input logic [NR-1:0] mask);
    int n;
    n = 0;
    while (any_pend(mask) && n < 100) begin step(0, 0); n++; end
    if (any_pend(mask)) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: mask %0h still pending after 100 cycles, required accept", mask);
      for (int i = 0; i < NR; i++) pv[i] = 0;
      drive();
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_busy || rq.size() != 0) && n < 100) begin step(0, 0); n++; end
    if (m_busy || rq.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL idle_timeout: transaction still open after 100 cycles, required completion");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < NR; i++) pv[i] = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  int exp_order[5] = '{0, 1, 2, 3, 0};
  int seen0;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, required $finish");
    $fatal(1, "global timeout");
  end

  initial begin
    seed16 = 16'($urandom);
    for (int i = 0; i < NR; i++) begin pv[i] = 0; pw[i] = 0; pa_q[i] = '0; pd[i] = '0; end
    drive();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values of the latched bus/response registers.
    @(negedge clk);
    chk("rst_resp_data", 64'(resp_data), 64'h0);
    chk("rst_resp_err", 64'(resp_err), 64'h0);
    chk("rst_waddr", 64'(reg_bus_waddr), 64'h0);
    chk("rst_araddr", 64'(reg_bus_araddr), 64'h0);
    chk("rst_wdata", 64'(reg_bus_wdata), 64'h0);
    @(posedge clk); #1;

    // Fairness: all four hold writes continuously.
    grant_log.delete();
    for (int i = 0; i < NR; i++) begin
      pw[i] = 1; pa_q[i] = {8'(i + 1), 8'(i)}; pd[i] = $urandom; pv[i] = 1;
    end
    drive();
    for (int n = 0; n < 60 && grant_log.size() < 5; n++) step(1, 0);
    for (int i = 0; i < NR; i++) pv[i] = 0;
    drive();
    wait_idle();
    for (int k = 0; k < 5; k++)
      chk($sformatf("grant_order_%0d", k), 64'((k < grant_log.size()) ? grant_log[k] : -1), 64'(exp_order[k]));

    // Single write, read with 4-cycle target latency, bad target.
    set_req(0, 1'b1, 16'h0310, 32'd5); wait_acc(4'b0001); wait_idle();
    force_lat = 4;
    set_req(1, 1'b0, 16'h0204, 32'h1234_5678); wait_acc(4'b0010); wait_idle();
    force_lat = 0;
    set_req(2, 1'b0, 16'h4000, 32'h0); wait_acc(4'b0100); wait_idle();

    // Read from a target that never answers.
    silent_tgt = 7;
    set_req(3, 1'b0, 16'h0700, 32'h0); wait_acc(4'b1000);
`ifdef REG_BUS_ARB_TIMEOUT_EN
    wait_idle();
`else
    seen0 = n_resp_seen;
    repeat (110) step(0, 0);
    chk("hang_no_resp", 64'(n_resp_seen - seen0), 64'h0);
    do_reset();
`endif
    silent_tgt = -1;

    // Reset while waiting for read data; the late return must be ignored.
    force_lat = 6;
    set_req(2, 1'b0, 16'h0500, 32'h0); wait_acc(4'b0100);
    step(0, 0);
    seen0 = n_resp_seen;
    do_reset();
    force_lat = 0;
    repeat (8) step(0, 0);
    chk("no_resp_after_reset", 64'(n_resp_seen - seen0), 64'h0);
    grant_log.delete();
    pw[0] = 1; pa_q[0] = 16'h0101; pd[0] = 32'hA; pv[0] = 1;
    pw[3] = 1; pa_q[3] = 16'h0202; pd[3] = 32'hB; pv[3] = 1;
    drive();
    wait_acc(4'b1001); wait_idle();
    chk("ptr_after_reset", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'h0);

    // Randomized traffic with stray returns from other targets.
    noise_en = 1;
    repeat (3000) step(0, 1);
    for (int i = 0; i < NR; i++) pv[i] = 0;
    drive();
    wait_idle();
    noise_en = 0;
    repeat (4) step(0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
